// File: rtl/uart_pkg.sv
// Shared types and constants for the oversampling UART receive path.
package uart_pkg;

  // Receiver frame states, in the order a frame is walked.
  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop1,
    StStop2
  } rx_state_t;

  // Parity mode encodings; 2'b11 also means no parity.
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_EVEN = 2'b10;

  // Bit positions inside error_flag.
  localparam int unsigned ERR_OVR = 3;
  localparam int unsigned ERR_PAR = 2;
  localparam int unsigned ERR_BRK = 1;
  localparam int unsigned ERR_FRM = 0;

  // True when the frame carries a parity bit.
  function automatic logic parity_enabled(logic [1:0] mode);
    return (mode == PAR_ODD) || (mode == PAR_EVEN);
  endfunction

endpackage

// File: rtl/uart_tick_gen.sv
// Oversample tick generator: divides the system clock by cfg_div + 1.
// Shared by the receive and transmit paths; clear realigns the tick phase.
module uart_tick_gen #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             clear,
  input  logic [DIV_W-1:0] cfg_div,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  // >= rather than == so a divisor lowered at runtime cannot strand the counter.
  assign tick = (cnt_q >= cfg_div);

  // Next count: wrap on tick, restart on clear.
  always_comb begin
    cnt_d = cnt_q + DIV_W'(1);
    if (clear || tick) begin
      cnt_d = '0;
    end
  end

  // Divisor counter register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver with runtime frame format, parity/stop/break
// checking and a valid/ready output with overrun detection.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int unsigned DATA_W  = 9,
  parameter int unsigned OS_RATE = 16,
  parameter int unsigned DIV_W   = 16
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic                      rx_in,
  input  logic [DIV_W-1:0]          cfg_div,
  input  logic [$clog2(DATA_W)-1:0] cfg_len,
  input  logic [1:0]                cfg_parity,
  input  logic                      cfg_stop2,
  input  logic                      rx_ready,
  output logic                      rx_valid,
  output logic [DATA_W-1:0]         rx_data,
  output logic [3:0]                error_flag,
  output logic                      active_flag
);

  localparam int unsigned LEN_W = $clog2(DATA_W);
  localparam int unsigned CNT_W = $clog2(DATA_W + 1);
  localparam int unsigned PH_W  = $clog2(OS_RATE);
  localparam int unsigned HALF  = OS_RATE / 2;

  // Synchroniser and edge detect
  logic [1:0] sync_q;
  logic       rx_prev_q;
  logic       rx_s;
  logic       rx_fall;

  // FSM
  rx_state_t state_q, state_d;
  logic      start_go;
  logic      sample_now;
  logic      frame_done;
  logic      tick;

  // Per-frame shadow configuration
  logic [LEN_W-1:0] len_q;
  logic [1:0]       par_q;
  logic             stop2_q;

  // Per-frame datapath
  logic [PH_W-1:0]   phase_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic [DATA_W-1:0] shift_q;
  logic              par_acc_q;
  logic              zero_q;
  logic              par_err_q;
  logic              brk_q;
  logic              frm_err_q;
  logic              done_q;

  // Output registers
  logic              valid_q;
  logic [DATA_W-1:0] data_q;
  logic [3:0]        err_q;
  logic [3:0]        err_new;

  assign rx_s    = sync_q[1];
  assign rx_fall = rx_prev_q & ~rx_s;

  // Two-flop synchroniser plus previous-value flop for falling-edge detect.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q    <= 2'b11;
      rx_prev_q <= 1'b1;
    end else begin
      sync_q    <= {sync_q[0], rx_in};
      rx_prev_q <= rx_s;
    end
  end

  // Tick phase restarts on the start edge so bit sampling is centred.
  uart_tick_gen #(
    .DIV_W(DIV_W)
  ) u_tick_gen (
    .clock  (clock),
    .reset_n(reset_n),
    .clear  (start_go),
    .cfg_div(cfg_div),
    .tick   (tick)
  );

  // FSM state register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic; every transition out of a non-idle state happens on a sample.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (rx_fall) state_d = StStart;
      end
      StStart: begin
        // A high line at mid start bit is a glitch, not a frame.
        if (sample_now) state_d = rx_s ? StIdle : StData;
      end
      StData: begin
        if (sample_now && (bit_cnt_q == CNT_W'(len_q))) begin
          state_d = parity_enabled(par_q) ? StParity : StStop1;
        end
      end
      StParity: begin
        if (sample_now) state_d = StStop1;
      end
      StStop1: begin
        if (sample_now) state_d = stop2_q ? StStop2 : StIdle;
      end
      StStop2: begin
        if (sample_now) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // FSM outputs: activity, start strobe, mid-bit sample strobe, final-sample strobe.
  always_comb begin
    active_flag = (state_q != StIdle);
    start_go    = (state_q == StIdle) && rx_fall;
    sample_now  = 1'b0;
    case (state_q)
      StIdle:  sample_now = 1'b0;
      StStart: sample_now = tick && (phase_q == PH_W'(HALF - 1));
      default: sample_now = tick && (phase_q == PH_W'(OS_RATE - 1));
    endcase
    frame_done = sample_now &&
                 (((state_q == StStop1) && !stop2_q) || (state_q == StStop2));
  end

  // Frame datapath: shadow config, tick phase, bit count, shift and error accumulation.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      len_q     <= '0;
      par_q     <= PAR_NONE;
      stop2_q   <= 1'b0;
      phase_q   <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_acc_q <= 1'b0;
      zero_q    <= 1'b1;
      par_err_q <= 1'b0;
      brk_q     <= 1'b0;
      frm_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= frame_done;
      if (start_go) begin
        len_q     <= cfg_len;
        par_q     <= cfg_parity;
        stop2_q   <= cfg_stop2;
        phase_q   <= '0;
        bit_cnt_q <= '0;
        shift_q   <= '0;
        par_acc_q <= 1'b0;
        zero_q    <= 1'b1;
        par_err_q <= 1'b0;
        brk_q     <= 1'b0;
        frm_err_q <= 1'b0;
      end else if ((state_q != StIdle) && tick) begin
        phase_q <= sample_now ? '0 : phase_q + PH_W'(1);
        if (sample_now) begin
          case (state_q)
            StData: begin
              shift_q   <= shift_q | (DATA_W'(rx_s) << bit_cnt_q);
              par_acc_q <= par_acc_q ^ rx_s;
              zero_q    <= zero_q & ~rx_s;
              bit_cnt_q <= bit_cnt_q + CNT_W'(1);
            end
            StParity: begin
              // Odd parity wants data ^ parity == 1, even wants 0.
              par_err_q <= (par_q == PAR_ODD) ? ~(par_acc_q ^ rx_s) : (par_acc_q ^ rx_s);
              zero_q    <= zero_q & ~rx_s;
            end
            StStop1: begin
              frm_err_q <= ~rx_s;
              brk_q     <= zero_q & ~rx_s;
            end
            StStop2: begin
              if (!rx_s) frm_err_q <= 1'b1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Status for the frame being delivered; overrun only if the old word was never taken.
  always_comb begin
    err_new          = '0;
    err_new[ERR_OVR] = valid_q & ~rx_ready;
    err_new[ERR_PAR] = par_err_q;
    err_new[ERR_BRK] = brk_q;
    err_new[ERR_FRM] = frm_err_q;
  end

  // Output word and handshake; a completing frame always wins over an accept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      data_q  <= '0;
      err_q   <= '0;
    end else if (done_q) begin
      valid_q <= 1'b1;
      data_q  <= shift_q;
      err_q   <= err_new;
    end else if (valid_q && rx_ready) begin
      valid_q <= 1'b0;
    end
  end

  assign rx_valid   = valid_q;
  assign rx_data    = data_q;
  assign error_flag = err_q;

endmodule

// File: tb/tb_uart_rx_os.sv
// Self-checking bench for uart_rx_os: directed frames plus randomised formats
// checked against a frame-level reference model.
module tb_uart_rx_os;

  localparam int unsigned DATA_W  = 9;
  localparam int unsigned OS_RATE = 16;
  localparam int unsigned DIV_W   = 16;
  localparam int unsigned LEN_W   = $clog2(DATA_W);

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic              rx_in = 1'b1;
  logic [DIV_W-1:0]  cfg_div = 16'd3;
  logic [LEN_W-1:0]  cfg_len = 4'd7;
  logic [1:0]        cfg_parity = 2'b00;
  logic              cfg_stop2 = 1'b0;
  logic              rx_ready = 1'b1;
  logic              rx_valid;
  logic [DATA_W-1:0] rx_data;
  logic [3:0]        error_flag;
  logic              active_flag;

  always #5 clock = ~clock;

  uart_rx_os #(
    .DATA_W (DATA_W),
    .OS_RATE(OS_RATE),
    .DIV_W  (DIV_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .rx_in      (rx_in),
    .cfg_div    (cfg_div),
    .cfg_len    (cfg_len),
    .cfg_parity (cfg_parity),
    .cfg_stop2  (cfg_stop2),
    .rx_ready   (rx_ready),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .error_flag (error_flag),
    .active_flag(active_flag)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: records accepted words and counts activity, sampled on the falling edge.
  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic [3:0]        err;
  } word_t;

  word_t got_q[$];
  int    valid_cycles = 0;
  int    active_cycles = 0;

  always @(negedge clock) begin
    if (rx_valid) valid_cycles++;
    if (active_flag) active_cycles++;
    if (rx_valid && rx_ready) got_q.push_back({rx_data, error_flag});
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  function automatic int bit_period();
    return OS_RATE * (int'(cfg_div) + 1);
  endfunction

  function automatic logic [DATA_W-1:0] len_mask(input int len_m1);
    logic [DATA_W-1:0] m;
    m = '0;
    for (int i = 0; i <= len_m1; i++) m[i] = 1'b1;
    return m;
  endfunction

  // Reference model: expected {error_flag, rx_data} for a frame as it appears on the wire.
  function automatic logic [DATA_W+3:0] model(input logic [DATA_W-1:0] data, input int len_m1,
                                              input logic [1:0] par, input logic stop2,
                                              input logic flip, input logic s1, input logic s2);
    logic [DATA_W-1:0] d;
    logic has_par, pbit, perr, brk, frm;
    d       = data & len_mask(len_m1);
    has_par = (par == 2'b01) || (par == 2'b10);
    pbit    = ((par == 2'b10) ? (^d) : ~(^d)) ^ flip;
    perr    = has_par && flip;
    frm     = !s1 || (stop2 && !s2);
    brk     = (d == '0) && (!has_par || !pbit) && !s1;
    return {1'b0, perr, brk, frm, d};
  endfunction

  // Drive one frame on rx_in; cfg is scrambled after the start bit to prove it is shadowed.
  task automatic send_frame(input logic [DATA_W-1:0] data, input int len_m1, input logic [1:0] par,
                            input logic stop2, input logic flip, input logic s1, input logic s2);
    int bp;
    logic [DATA_W-1:0] d;
    bp         = bit_period();
    d          = data & len_mask(len_m1);
    cfg_len    = LEN_W'(len_m1);
    cfg_parity = par;
    cfg_stop2  = stop2;
    wait_cycles(1);
    rx_in = 1'b0;
    wait_cycles(bp);
    cfg_len    = LEN_W'($urandom_range(4, 8));
    cfg_parity = 2'($urandom);
    cfg_stop2  = 1'($urandom);
    for (int i = 0; i <= len_m1; i++) begin
      rx_in = d[i];
      wait_cycles(bp);
    end
    if ((par == 2'b01) || (par == 2'b10)) begin
      rx_in = ((par == 2'b10) ? (^d) : ~(^d)) ^ flip;
      wait_cycles(bp);
    end
    rx_in = s1;
    wait_cycles(bp);
    if (stop2) begin
      rx_in = s2;
      wait_cycles(bp);
    end
    rx_in = 1'b1;
    wait_cycles(2 * bp);
  endtask

  // Send a frame with rx_ready high and compare the single accepted word with the model.
  task automatic frame_case(input string tag, input logic [DATA_W-1:0] data, input int len_m1,
                            input logic [1:0] par, input logic stop2, input logic flip,
                            input logic s1, input logic s2);
    int start;
    logic [DATA_W+3:0] exp;
    word_t w;
    exp   = model(data, len_m1, par, stop2, flip, s1, s2);
    start = got_q.size();
    send_frame(data, len_m1, par, stop2, flip, s1, s2);
    check_eq({tag, ".words"}, got_q.size() - start, 1);
    if (got_q.size() > start) begin
      w = got_q[start];
      check_eq({tag, ".data"}, 32'(w.data), 32'(exp[DATA_W-1:0]));
      check_eq({tag, ".err"}, 32'(w.err), 32'(exp[DATA_W+3:DATA_W]));
    end
  endtask

  initial begin
    repeat (90000) @(posedge clock);
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "bench timed out");
  end

  initial begin
    int a0, v0, g0, bp;

    // Reset state.
    wait_cycles(4);
    check_eq("rst.valid", 32'(rx_valid), 0);
    check_eq("rst.data", 32'(rx_data), 0);
    check_eq("rst.err", 32'(error_flag), 0);
    check_eq("rst.active", 32'(active_flag), 0);
    reset_n = 1'b1;
    wait_cycles(10);

    // 8N1 0xA5: one valid pulse, 9.5 bit periods of activity.
    a0 = active_cycles;
    v0 = valid_cycles;
    frame_case("8n1_a5", 9'h0A5, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("8n1_a5.active", active_cycles - a0, (OS_RATE * 19 / 2) * 4);
    check_eq("8n1_a5.pulse", valid_cycles - v0, 1);

    // 7E2: good parity, then a wrong parity bit.
    frame_case("7e2_ok", 9'h05A, 6, 2'b10, 1'b1, 1'b0, 1'b1, 1'b1);
    frame_case("7e2_bad", 9'h05A, 6, 2'b10, 1'b1, 1'b1, 1'b1, 1'b1);

    // 9-bit odd parity with bad stop; all-zero frame gives break.
    frame_case("9o1_frm", 9'h1B3, 8, 2'b01, 1'b0, 1'b0, 1'b0, 1'b1);
    frame_case("9e1_brk", 9'h000, 8, 2'b10, 1'b0, 1'b0, 1'b0, 1'b1);

    // Short low glitch is a false start.
    bp = bit_period();
    v0 = valid_cycles;
    g0 = got_q.size();
    rx_in = 1'b0;
    wait_cycles(5 * (int'(cfg_div) + 1));
    check_eq("glitch.active_mid", 32'(active_flag), 1);
    rx_in = 1'b1;
    wait_cycles(2 * bp);
    check_eq("glitch.active_end", 32'(active_flag), 0);
    check_eq("glitch.no_valid", valid_cycles - v0, 0);
    check_eq("glitch.no_word", got_q.size() - g0, 0);
    frame_case("after_glitch", 9'h03C, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

    // Randomised formats, divisors and error injections.
    for (int n = 0; n < 12; n++) begin
      logic [DATA_W-1:0] d;
      cfg_div = DIV_W'($urandom_range(0, 3));
      wait_cycles(8);
      d = ($urandom_range(0, 4) == 0) ? '0 : DATA_W'($urandom);
      frame_case($sformatf("rand%0d", n), d, $urandom_range(4, 8), 2'($urandom), 1'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) != 0),
                 ($urandom_range(0, 4) != 0));
    end
    cfg_div = 16'd3;
    wait_cycles(8);
    bp = bit_period();

    // Overrun: two frames unaccepted, newest wins with overrun flagged.
    rx_ready = 1'b0;
    send_frame(9'h011, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ovr.first_err", 32'(error_flag), 0);
    send_frame(9'h022, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);
    check_eq("ovr.valid", 32'(rx_valid), 1);
    check_eq("ovr.data", 32'(rx_data), 32'h022);
    check_eq("ovr.err", 32'(error_flag), 32'h8);
    rx_ready = 1'b1;
    @(negedge clock);
    check_eq("ovr.accept_cycle", 32'(rx_valid), 1);
    @(negedge clock);
    check_eq("ovr.dropped", 32'(rx_valid), 0);
    wait_cycles(4);

    // Reset in the middle of DATA aborts the frame and clears outputs.
    rx_in = 1'b0;
    wait_cycles(bp);
    rx_in = 1'b1;
    wait_cycles(bp);
    rx_in = 1'b0;
    wait_cycles(bp / 2);
    check_eq("midrst.active_before", 32'(active_flag), 1);
    reset_n = 1'b0;
    wait_cycles(3);
    check_eq("midrst.valid", 32'(rx_valid), 0);
    check_eq("midrst.data", 32'(rx_data), 0);
    check_eq("midrst.err", 32'(error_flag), 0);
    check_eq("midrst.active", 32'(active_flag), 0);
    rx_in = 1'b1;
    wait_cycles(5);
    reset_n = 1'b1;
    wait_cycles(2 * bp);
    frame_case("after_rst_81", 9'h081, 7, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
# uart_rx_os

Parametrised oversampling UART receiver, the successor to the fixed 8-bit receive path in the APB-UART subsystem. Synchronises the serial line, detects and validates the start bit, samples each bit at mid-period using an OS_RATE oversample tick, and checks parity and stop bits. Frame format is runtime-configurable. The received word and its error status are presented on a valid/ready handshake with overrun detection, for the APB register block or a receive FIFO.

## Interface
- DATA_W, 9: maximum data bits per frame; the `rx_data` width.
- OS_RATE, 16: oversample ticks per bit; even, ≥ 4.
- DIV_W, 16: width of the tick divisor.
- clock  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- rx_in  in  1  serial line; idles high; asynchronous to `clock`.
- cfg_div  in  DIV_W  clock cycles per oversample tick, minus 1.
- cfg_len  in  $clog2(DATA_W)  data bits minus 1; legal range 4..DATA_W-1.
- cfg_parity  in  2  00 none, 01 odd, 10 even, 11 none.
- cfg_stop2  in  1  expect two stop bits.
- rx_ready  in  1  consumer accepts the word.
- rx_valid  out  1  word plus status are available.
- rx_data  out  DATA_W  LSB-first data, right-aligned; unused upper bits 0.
- error_flag  out  4  [3] overrun, [2] parity, [1] break, [0] framing (stop).
- active_flag  out  1  a frame is being received.

## Operation
- `rx_in` passes through a 2-FF synchroniser; all logic uses the synchronised value `rx_s`.
- Tick generator: a counter runs 0..cfg_div and emits a 1-cycle `tick` when it reaches cfg_div. With cfg_div = 0, `tick` is asserted every cycle.
- FSM states: IDLE, START, DATA, PARITY, STOP1, STOP2.
- IDLE: on a falling edge of `rx_s`:
  - latch cfg_len, cfg_parity and cfg_stop2 into shadow registers; cfg changes mid-frame have no effect;
  - clear the tick phase counter and go to START.
- START: after OS_RATE/2 ticks, sample `rx_s`.
  - 1: false start; return to IDLE silently, report nothing.
  - 0: go to DATA.
- Bit-period rule: from START onward, each bit is sampled once, every OS_RATE ticks (mid-bit).
- DATA: shift samples in LSB-first; after cfg_len+1 bits go to PARITY, or to STOP1 if parity is none.
- PARITY: sample the bit and compare with the computed parity.
  - even: the XOR of data bits and the parity bit must be 0.
  - odd: that XOR must be 1.
- STOP1: sample the stop bit.
  - 0 sets framing error.
  - go to STOP2 if cfg_stop2, otherwise complete.
- STOP2: sample again; 0 sets framing error; then complete.
- Break: all data bits 0, the parity bit (if any) 0, and the first stop sample 0. Break sets bit 1 as well as bit 0.
- Completion, on the clock after the final stop sample:
  - load `rx_data` and error bits [2:0], and assert `rx_valid`;
  - if `rx_valid` was still high with `rx_ready` low, set bit 3 (overrun) and overwrite with the new frame (newest wins).
- The FSM returns to IDLE immediately after completion and can detect a new start edge on the next cycle.
- `active_flag` = (state != IDLE).

## Timing
- Reset values: `rx_valid` 0, `rx_data` 0, `error_flag` 0, `active_flag` 0, FSM IDLE, synchroniser flops 1. Reset mid-frame aborts the frame with no output.
- Start-edge latency: 2 cycles for synchronisation plus 1 for edge detect.
- `rx_valid` handshake:
  - stays high until a cycle with `rx_valid && rx_ready`; it drops the following cycle;
  - `rx_data` and `error_flag` are stable while `rx_valid` is high, unless an overrun overwrites them.
- Simultaneous accept and completion in the same cycle: no overrun; the new word is loaded and `rx_valid` stays 1.
- Bit counter width is $clog2(DATA_W+1). Phase counter width is $clog2(OS_RATE).

## Structure
- Package `uart_pkg`:
  - enum `rx_state_t`;
  - parity encodings PAR_NONE, PAR_ODD, PAR_EVEN;
  - error bit index constants ERR_OVR, ERR_PAR, ERR_BRK, ERR_FRM.
- Sub-module `uart_tick_gen`: the divisor counter producing `tick`, reusable by the transmitter. The FSM, shift register and synchroniser live in `uart_rx_os`.

## Test plan
- 8N1, cfg_div = 3, OS_RATE = 16, byte 0xA5, `rx_ready` high → `rx_valid` pulses once with `rx_data` = 0x0A5 and `error_flag` = 0; `active_flag` high for 9.5 bit periods.
- 7E2, data 0x5A, correct parity then a wrong parity bit → first frame: `error_flag` 0; second: `error_flag` = 4'b0100, `rx_data` = 0x05A.
- 9-bit odd parity, stop bit forced 0 → `error_flag` = 4'b0001. All-zero frame with stop 0 → `error_flag` = 4'b0011, `rx_data` = 0.
- Low glitch on `rx_in` of 5 ticks during IDLE → no `rx_valid`; FSM back in IDLE; a following valid 0x3C frame is received correctly.
- Two frames 0x11 then 0x22 with `rx_ready` low throughout → `rx_data` = 0x022 with `error_flag[3]` = 1. Then raise `rx_ready` → `rx_valid` drops the next cycle.
- Assert `reset_n` low during DATA, release, then send 0x81 → all outputs are 0 during reset; 0x81 is received with no error.
